// File: rtl/vadd_pkg.sv
// ============================================================================
// Module      : vadd_pkg
// Description : Shared constants for the vector-add AXIS transmitter slice.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vadd_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Wide enough for a 512-bit stream; users slice off the low bytes they need.
    localparam int unsigned         AXIS_KEEP_MAX_W = 64;
    localparam logic [AXIS_KEEP_MAX_W-1:0] AXIS_KEEP_ALL = '1;

    function automatic int unsigned fifo_aw(input int unsigned depth);
        return $clog2(depth);
    endfunction

endpackage

`default_nettype wire

// File: rtl/vadd_sync_fifo.sv
// ============================================================================
// Module      : vadd_sync_fifo
// Description : Single-clock FIFO with registered full flag and head-of-queue read.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vadd_sync_fifo
    import vadd_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int unsigned  AW          = fifo_aw(DEPTH);
    localparam logic [AW:0]  C_DEPTH     = (AW + 1)'(DEPTH);
    localparam logic [AW:0]  C_CNT_ONE   = (AW + 1)'(1);
    localparam logic [AW-1:0] C_PTR_ONE  = AW'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic [AW:0]      w_count_nxt;
    logic             r_full;
    logic             w_push_ok;
    logic             w_pop_ok;

    // A push against a full FIFO is lost even if a pop frees a slot this cycle.
    assign w_push_ok = push && !r_full;
    assign w_pop_ok  = pop && (r_count != '0);

    always_comb begin
        w_count_nxt = r_count;
        if (w_push_ok && !w_pop_ok) begin
            w_count_nxt = r_count + C_CNT_ONE;
        end else if (!w_push_ok && w_pop_ok) begin
            w_count_nxt = r_count - C_CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == C_DEPTH);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    assign full  = r_full;
    assign empty = (r_count == '0);
    assign head  = r_mem[r_rd_ptr];

endmodule

`default_nettype wire

// File: rtl/vadd_axis_tx.sv
// ============================================================================
// Module      : vadd_axis_tx
// Description : AXI4-Stream master that sends `len` FIFO words per ap_start.
//               Define VADD_AXIS_TX_STATS_EN to add stall/starve counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vadd_axis_tx
    import vadd_pkg::*;
#(
    parameter int unsigned C_AXIS_TDATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH         = 16,
    parameter int unsigned LEN_WIDTH          = 32
) (
    input  logic                            ap_aclk,
    input  logic                            ap_areset,
    input  logic                            ap_start,
    input  logic [LEN_WIDTH-1:0]            len,
    output logic                            ap_idle,
    output logic                            ap_done,
    input  logic                            s_wr_en,
    input  logic [C_AXIS_TDATA_WIDTH-1:0]   s_wr_data,
    output logic                            s_wr_full,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic [C_AXIS_TDATA_WIDTH-1:0]   m_axis_tdata,
    output logic [C_AXIS_TDATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic                            m_axis_tlast
`ifdef VADD_AXIS_TX_STATS_EN
    ,
    output logic [31:0]                     stall_cnt,
    output logic [31:0]                     starve_cnt
`endif
);

    localparam int unsigned          KEEP_W    = C_AXIS_TDATA_WIDTH / 8;
    localparam logic [LEN_WIDTH-1:0] C_LEN_ONE = LEN_WIDTH'(1);

    logic [1:0]                    r_state;
    logic [1:0]                    w_state_nxt;
    logic [LEN_WIDTH-1:0]          r_len_q;
    logic [LEN_WIDTH-1:0]          r_issued;
    logic                          r_tvalid;
    logic                          r_tlast;
    logic [C_AXIS_TDATA_WIDTH-1:0] r_tdata;
    logic                          w_fifo_empty;
    logic                          w_fifo_full;
    logic [C_AXIS_TDATA_WIDTH-1:0] w_fifo_head;
    logic                          w_start_ok;
    logic                          w_hs;
    logic                          w_load;

    vadd_sync_fifo #(
        .WIDTH (C_AXIS_TDATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (ap_aclk),
        .rst       (ap_areset),
        .push      (s_wr_en),
        .push_data (s_wr_data),
        .pop       (w_load),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty),
        .head      (w_fifo_head)
    );

    assign w_start_ok = (r_state == ST_IDLE) && ap_start;
    assign w_hs       = r_tvalid && m_axis_tready;
    // Refill on the handshake cycle itself so back-to-back beats need no bubble.
    assign w_load     = (r_state == ST_RUN) && !w_fifo_empty
                        && (r_issued < r_len_q) && (!r_tvalid || m_axis_tready);

    always_ff @(posedge ap_aclk) begin
        if (ap_areset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (ap_start) begin
                    w_state_nxt = (len == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_hs && r_tlast) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        ap_idle = (r_state == ST_IDLE);
        ap_done = (r_state == ST_DONE);
    end

    always_ff @(posedge ap_aclk) begin
        if (ap_areset) begin
            r_len_q  <= '0;
            r_issued <= '0;
            r_tvalid <= 1'b0;
            r_tlast  <= 1'b0;
            r_tdata  <= '0;
        end else begin
            if (w_start_ok) begin
                r_len_q  <= len;
                r_issued <= '0;
            end
            if (w_load) begin
                r_tvalid <= 1'b1;
                r_tdata  <= w_fifo_head;
                r_tlast  <= (r_issued == r_len_q - C_LEN_ONE);
                r_issued <= r_issued + C_LEN_ONE;
            end else if (w_hs) begin
                r_tvalid <= 1'b0;
                r_tlast  <= 1'b0;
            end
        end
    end

`ifdef VADD_AXIS_TX_STATS_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_starve_cnt;

    always_ff @(posedge ap_aclk) begin
        if (ap_areset || w_start_ok) begin
            r_stall_cnt  <= '0;
            r_starve_cnt <= '0;
        end else if (r_state == ST_RUN) begin
            if (r_tvalid && !m_axis_tready && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (!r_tvalid && w_fifo_empty && (r_starve_cnt != '1)) begin
                r_starve_cnt <= r_starve_cnt + 32'd1;
            end
        end
    end

    assign stall_cnt  = r_stall_cnt;
    assign starve_cnt = r_starve_cnt;
`endif

    assign s_wr_full     = w_fifo_full;
    assign m_axis_tvalid = r_tvalid;
    assign m_axis_tdata  = r_tdata;
    assign m_axis_tlast  = r_tlast;
    assign m_axis_tkeep  = AXIS_KEEP_ALL[KEEP_W-1:0];

endmodule

`default_nettype wire
